conv1x1_tile_sched: RTL and testbench

//  Tile scheduler for the 1x1 conv kernel (conv2d_1x1). Splits the output feature map into

---
 rtl/conv1x1_tile_sched.sv | 151 +++++++++++++++
 tb/tb_conv1x1_tile_sched.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/conv1x1_tile_sched.sv
// Tile scheduler for the 1x1 conv kernel: walks the output feature map in row-major
// tiles, launching the kernel per tile and waiting for a fresh conv_done rising edge.
module conv1x1_tile_sched #(
    parameter int FMS_WIDTH    = 8,
    parameter int TILE_H       = 8,
    parameter int TILE_W       = 8,
    parameter int PC_ROW_WIDTH = 4,
    parameter int PC_COL_WIDTH = 4,
    parameter int TC_ROW_WIDTH = 3,
    parameter int TC_COL_WIDTH = 3
) (
    input  logic                                 clk,
    input  logic                                 rstn,
    input  logic                                 start,
    input  logic                                 abort,
    input  logic                                 cfg_stride,
    input  logic [FMS_WIDTH-1:0]                 cfg_ifm_size,
    input  logic                                 conv_done,
    output logic                                 start_conv,
    output logic [PC_ROW_WIDTH-1:0]              tile_row_offset,
    output logic [PC_COL_WIDTH-1:0]              tile_col_offset,
    output logic [TC_ROW_WIDTH-1:0]              tc_row_max,
    output logic [TC_COL_WIDTH-1:0]              tc_col_max,
    output logic                                 busy,
    output logic                                 done,
    output logic [PC_ROW_WIDTH+PC_COL_WIDTH-1:0] tiles_done
);

    localparam int OFM_W = FMS_WIDTH + 1;
    localparam logic [OFM_W-1:0] TH = OFM_W'(TILE_H);
    localparam logic [OFM_W-1:0] TW = OFM_W'(TILE_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CALC,
        S_LAUNCH,
        S_WAIT,
        S_NEXT,
        S_DONE
    } state_t;

    state_t state, state_nx;

    logic [OFM_W-1:0] ofm;
    logic [OFM_W-1:0] n_tr, n_tc;
    logic [OFM_W-1:0] row_idx, col_idx;
    logic [OFM_W-1:0] row_nx, col_nx;
    logic             conv_done_q;
    logic             done_edge;
    logic             last_tile;

    // Rows (or cols) covered by tile idx, minus one; the last tile may be partial.
    function automatic logic [OFM_W-1:0] extent_m1(input logic [OFM_W-1:0] size,
                                                   input logic [OFM_W-1:0] idx,
                                                   input logic [OFM_W-1:0] tile);
        logic [OFM_W-1:0] rem;
        rem = size - idx * tile;
        return ((rem > tile) ? tile : rem) - 1'b1;
    endfunction

    assign n_tr      = (ofm + TH - 1'b1) / TH;
    assign n_tc      = (ofm + TW - 1'b1) / TW;
    assign done_edge = conv_done & ~conv_done_q;
    assign last_tile = (row_idx == n_tr - 1'b1) && (col_idx == n_tc - 1'b1);

    always_comb begin
        row_nx = row_idx;
        col_nx = col_idx + 1'b1;
        if (col_idx == n_tc - 1'b1) begin
            col_nx = '0;
            row_nx = row_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (start) state_nx = S_CALC;
            S_CALC:   state_nx = (ofm != '0) ? S_LAUNCH : S_DONE;
            S_LAUNCH: state_nx = S_WAIT;
            S_WAIT:   if (done_edge) state_nx = S_NEXT;
            S_NEXT:   state_nx = last_tile ? S_DONE : S_LAUNCH;
            S_DONE:   state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
        if (abort) state_nx = S_IDLE;
    end

    // Tile outputs are loaded only on the way into LAUNCH, so they hold through WAIT/DONE.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ofm             <= '0;
            row_idx         <= '0;
            col_idx         <= '0;
            conv_done_q     <= 1'b0;
            tile_row_offset <= '0;
            tile_col_offset <= '0;
            tc_row_max      <= '0;
            tc_col_max      <= '0;
            tiles_done      <= '0;
        end else begin
            conv_done_q <= conv_done;
            if (!abort) begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            ofm        <= cfg_stride ? ({1'b0, cfg_ifm_size} + 1'b1) >> 1
                                                     : {1'b0, cfg_ifm_size};
                            tiles_done <= '0;
                        end
                    end
                    S_CALC: begin
                        row_idx <= '0;
                        col_idx <= '0;
                        if (ofm != '0) begin
                            tile_row_offset <= '0;
                            tile_col_offset <= '0;
                            tc_row_max      <= TC_ROW_WIDTH'(extent_m1(ofm, '0, TH));
                            tc_col_max      <= TC_COL_WIDTH'(extent_m1(ofm, '0, TW));
                        end
                    end
                    S_NEXT: begin
                        tiles_done <= tiles_done + 1'b1;
                        row_idx    <= row_nx;
                        col_idx    <= col_nx;
                        if (!last_tile) begin
                            tile_row_offset <= PC_ROW_WIDTH'(row_nx);
                            tile_col_offset <= PC_COL_WIDTH'(col_nx);
                            tc_row_max      <= TC_ROW_WIDTH'(extent_m1(ofm, row_nx, TH));
                            tc_col_max      <= TC_COL_WIDTH'(extent_m1(ofm, col_nx, TW));
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign start_conv = (state == S_LAUNCH);
    assign busy       = (state != S_IDLE);
    assign done       = (state == S_DONE);

endmodule

// File: tb/tb_conv1x1_tile_sched.sv
// Randomized self-checking bench for conv1x1_tile_sched; expected tile sequences come
// from a plain-arithmetic model of the row-major tiling.
module tb_conv1x1_tile_sched;

    logic       clk;
    logic       rstn;
    logic       start;
    logic       abort;
    logic       cfg_stride;
    logic [7:0] cfg_ifm_size;
    logic       conv_done;
    logic       start_conv;
    logic [3:0] tile_row_offset;
    logic [3:0] tile_col_offset;
    logic [2:0] tc_row_max;
    logic [2:0] tc_col_max;
    logic       busy;
    logic       done;
    logic [7:0] tiles_done;

    int n_checks = 0;
    int n_errors = 0;

    conv1x1_tile_sched dut (
        .clk             (clk),
        .rstn            (rstn),
        .start           (start),
        .abort           (abort),
        .cfg_stride      (cfg_stride),
        .cfg_ifm_size    (cfg_ifm_size),
        .conv_done       (conv_done),
        .start_conv      (start_conv),
        .tile_row_offset (tile_row_offset),
        .tile_col_offset (tile_col_offset),
        .tc_row_max      (tc_row_max),
        .tc_col_max      (tc_col_max),
        .busy            (busy),
        .done            (done),
        .tiles_done      (tiles_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    function automatic int min_int(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Runs one job from IDLE; abort_tile >= 0 aborts during WAIT of that tile index.
    task automatic applyStimulus(input int ifm, input int stride, input int abort_tile);
        int ofm, ntr, ntc, n, r, c, keep;
        ofm = stride ? (ifm + 1) / 2 : ifm;
        ntr = (ofm + 7) / 8;
        ntc = (ofm + 7) / 8;
        n   = ntr * ntc;
        $display("[TB] job ifm=%0d stride=%0d ofm=%0d tiles=%0d", ifm, stride, ofm, n);
        start        = 1'b1;
        cfg_ifm_size = 8'(ifm);
        cfg_stride   = stride[0];
        @(posedge clk);
        #1;
        start        = 1'b0;
        cfg_ifm_size = 8'($urandom);
        cfg_stride   = 1'($urandom);
        @(negedge clk);
        checkOutput("calc_busy", busy, 1);
        checkOutput("calc_start_conv", start_conv, 0);
        if (n == 0) begin
            @(negedge clk);
            checkOutput("empty_done", done, 1);
            checkOutput("empty_busy", busy, 1);
            checkOutput("empty_start_conv", start_conv, 0);
            @(negedge clk);
            checkOutput("empty_done_after", done, 0);
            checkOutput("empty_busy_after", busy, 0);
            return;
        end
        for (int i = 0; i < n; i++) begin
            r = i / ntc;
            c = i % ntc;
            @(negedge clk);
            checkOutput("launch_start_conv", start_conv, 1);
            checkOutput("launch_row_off", tile_row_offset, r);
            checkOutput("launch_col_off", tile_col_offset, c);
            checkOutput("launch_row_max", tc_row_max, min_int(8, ofm - r * 8) - 1);
            checkOutput("launch_col_max", tc_col_max, min_int(8, ofm - c * 8) - 1);
            checkOutput("launch_tiles_done", tiles_done, i);
            checkOutput("launch_done", done, 0);
            if (i == abort_tile) begin
                @(negedge clk);
                abort = 1'b1;
                @(posedge clk);
                #1;
                abort = 1'b0;
                @(negedge clk);
                checkOutput("abort_busy", busy, 0);
                checkOutput("abort_start_conv", start_conv, 0);
                checkOutput("abort_tiles_done", tiles_done, i);
                repeat (3) begin
                    @(negedge clk);
                    checkOutput("abort_no_done", done, 0);
                    checkOutput("abort_idle", busy, 0);
                end
                return;
            end
            keep = $urandom_range(0, 2);
            repeat (keep) begin
                @(negedge clk);
                checkOutput("wait_hold_start_conv", start_conv, 0);
                checkOutput("wait_hold_busy", busy, 1);
                start = 1'($urandom);
                cfg_ifm_size = 8'($urandom);
            end
            @(negedge clk);
            start = 1'b0;
            conv_done = 1'b0;
            checkOutput("wait_start_conv", start_conv, 0);
            @(negedge clk);
            conv_done = 1'b1;
            checkOutput("wait_low_start_conv", start_conv, 0);
            @(negedge clk);
            checkOutput("next_start_conv", start_conv, 0);
            checkOutput("next_done", done, 0);
            if ($urandom_range(0, 1) == 1) conv_done = 1'b0;
        end
        @(negedge clk);
        checkOutput("job_done", done, 1);
        checkOutput("job_busy", busy, 1);
        checkOutput("job_start_conv", start_conv, 0);
        checkOutput("job_tiles_done", tiles_done, n);
        @(negedge clk);
        checkOutput("idle_done", done, 0);
        checkOutput("idle_busy", busy, 0);
        checkOutput("hold_row_off", tile_row_offset, ntr - 1);
        checkOutput("hold_col_off", tile_col_offset, ntc - 1);
        checkOutput("hold_tiles_done", tiles_done, n);
    endtask

    initial begin
        rstn         = 1'b0;
        start        = 1'b0;
        abort        = 1'b0;
        cfg_stride   = 1'b0;
        cfg_ifm_size = '0;
        conv_done    = 1'b0;
        #22;
        checkOutput("rst_start_conv", start_conv, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_tiles_done", tiles_done, 0);
        checkOutput("rst_row_off", tile_row_offset, 0);
        checkOutput("rst_col_max", tc_col_max, 0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        applyStimulus(16, 0, -1);
        applyStimulus(20, 0, -1);
        applyStimulus(15, 1, -1);
        applyStimulus(0, 0, -1);
        applyStimulus(20, 0, 2);
        applyStimulus(20, 0, -1);

        start        = 1'b1;
        abort        = 1'b1;
        cfg_ifm_size = 8'd16;
        cfg_stride   = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        checkOutput("abort_start_busy", busy, 0);
        @(negedge clk);
        checkOutput("abort_start_no_launch", start_conv, 0);
        checkOutput("abort_start_still_idle", busy, 0);

        for (int j = 0; j < 8; j++) begin
            applyStimulus(int'($urandom_range(0, 128)), int'($urandom_range(0, 1)), -1);
        end

        start        = 1'b1;
        cfg_ifm_size = 8'd16;
        cfg_stride   = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b0;
        #1;
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_start_conv", start_conv, 0);
        checkOutput("midrst_done", done, 0);
        checkOutput("midrst_col_off", tile_col_offset, 0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("midrst_no_done", done, 0);
        checkOutput("midrst_idle", busy, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
